// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// nes_pkg : shared NES controller types and constants
// Rev 1.0 : initial release
// ============================================================================
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    LAT_LO = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } joypad_state_t;

  localparam logic [7:0] JOY_OPEN_BUS = 8'h40;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage : nes_pkg
`default_nettype wire

// File: rtl/joypad_if_if.sv
`default_nettype none
// ============================================================================
// joypad_if_if : CPU-side register access bus for $4016/$4017
// Rev 1.0 : initial release
// ============================================================================
interface joypad_if_if;
  logic       clock_en;
  logic       io_en;
  logic       io_rw;
  logic       io_port;
  logic [7:0] io_wr_data;
  logic [7:0] io_rd_data;

  modport master (output clock_en, io_en, io_rw, io_port, io_wr_data,
                  input  io_rd_data);
  modport slave  (input  clock_en, io_en, io_rw, io_port, io_wr_data,
                  output io_rd_data);
endinterface : joypad_if_if
`default_nettype wire

// File: rtl/joypad_poller.sv
`default_nettype none
// ============================================================================
// joypad_poller : pad-bus tick generator, input synchroniser, poll FSM and
//                 snapshot registers. Macro JOYPAD_P2_EN builds the P2 path.
// Rev 1.0 : initial release
// ============================================================================
module joypad_poller
  import nes_pkg::*;
#(
  parameter int TICK_DIV   = 256,
  parameter int POLL_TICKS = 512
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] snap_p1,
  output logic [7:0] snap_p2,
  output logic [7:0] snap_nxt_p1,
  output logic [7:0] snap_nxt_p2
);

  localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int PW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_TICKS - 1);

  logic [1:0]    r_sync1, r_sync2;
  logic [1:0]    w_pressed;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [PW-1:0] r_poll_cnt;
  logic          r_ph;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_work_p1, r_snap_p1;
  joypad_state_t r_state, w_state_nxt;

  assign w_pressed = ~r_sync2;
  assign w_tick    = (r_tick_cnt == TICK_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= pad_data;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    pad_latch   = 1'b0;
    pad_clk     = 1'b0;
    case (r_state)
      IDLE:    if (w_tick && r_poll_cnt == POLL_MAX) w_state_nxt = LATCH;
      LATCH: begin
        pad_latch = 1'b1;
        if (w_tick && r_ph) w_state_nxt = LAT_LO;
      end
      LAT_LO:  if (w_tick) w_state_nxt = CLK_HI;
      CLK_HI: begin
        pad_clk = 1'b1;
        if (w_tick) w_state_nxt = CLK_LO;
      end
      CLK_LO:  if (w_tick) w_state_nxt = (r_bit_cnt == 3'd7) ? DONE : CLK_HI;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt <= '0;
      r_ph       <= 1'b0;
      r_bit_cnt  <= '0;
      r_work_p1  <= '0;
      r_snap_p1  <= '0;
    end else begin
      case (r_state)
        IDLE:   if (w_tick) r_poll_cnt <= (r_poll_cnt == POLL_MAX) ? '0 : r_poll_cnt + PW'(1);
        LATCH:  if (w_tick) r_ph <= ~r_ph;
        LAT_LO: if (w_tick) begin
          r_work_p1[0] <= w_pressed[0];
          r_bit_cnt    <= 3'd1;
        end
        CLK_LO: if (w_tick) begin
          r_work_p1[r_bit_cnt] <= w_pressed[0];
          r_bit_cnt            <= r_bit_cnt + 3'd1;
        end
        DONE: begin
          r_snap_p1  <= r_work_p1;
          r_poll_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign snap_p1     = r_snap_p1;
  // Value the snapshot takes at the next edge, so a coincident strobe load sees it.
  assign snap_nxt_p1 = (r_state == DONE) ? r_work_p1 : r_snap_p1;

`ifdef JOYPAD_P2_EN
  logic [7:0] r_work_p2, r_snap_p2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work_p2 <= '0;
      r_snap_p2 <= '0;
    end else begin
      if (w_tick && r_state == LAT_LO) r_work_p2[0]         <= w_pressed[1];
      if (w_tick && r_state == CLK_LO) r_work_p2[r_bit_cnt] <= w_pressed[1];
      if (r_state == DONE)             r_snap_p2            <= r_work_p2;
    end
  end

  assign snap_p2     = r_snap_p2;
  assign snap_nxt_p2 = (r_state == DONE) ? r_work_p2 : r_snap_p2;
`else
  logic w_unused_p2;
  assign w_unused_p2 = w_pressed[1];
  assign snap_p2     = 8'h00;
  assign snap_nxt_p2 = 8'h00;
`endif

endmodule : joypad_poller
`default_nettype wire

// File: rtl/joypad_if.sv
`default_nettype none
// ============================================================================
// joypad_if : $4016/$4017 controller port - strobe, shift registers, read mux.
//             Macro JOYPAD_P2_EN builds the P2 ($4017) shift path.
// Rev 1.0 : initial release
// ============================================================================
module joypad_if
  import nes_pkg::*;
#(
  parameter int TICK_DIV   = 256,
  parameter int POLL_TICKS = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  joypad_if_if.slave  bus,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic [1:0]  pad_data,
  output logic [7:0]  snap_p1,
  output logic [7:0]  snap_p2
);

  logic [7:0] w_snap_nxt_p1, w_snap_nxt_p2;
  logic       r_strobe;
  logic [7:0] r_shift_p1;
  logic       w_wr, w_rd, w_shift_p1;
  logic       w_unused_bits;

  joypad_poller #(
    .TICK_DIV   (TICK_DIV),
    .POLL_TICKS (POLL_TICKS)
  ) u_poller (
    .clock       (clock),
    .reset_n     (reset_n),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .snap_p1     (snap_p1),
    .snap_p2     (snap_p2),
    .snap_nxt_p1 (w_snap_nxt_p1),
    .snap_nxt_p2 (w_snap_nxt_p2)
  );

  // $4017 writes belong to the APU frame counter and are ignored here.
  assign w_wr       = bus.clock_en & bus.io_en & bus.io_rw & ~bus.io_port;
  assign w_rd       = bus.io_en & ~bus.io_rw;
  assign w_shift_p1 = w_rd & bus.clock_en & ~r_strobe & ~bus.io_port;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  r_strobe <= 1'b0;
    else if (w_wr) r_strobe <= bus.io_wr_data[0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        r_shift_p1 <= '0;
    else if (r_strobe)   r_shift_p1 <= w_snap_nxt_p1;
    else if (w_shift_p1) r_shift_p1 <= {1'b1, r_shift_p1[7:1]};
  end

`ifdef JOYPAD_P2_EN
  logic [7:0] r_shift_p2;
  logic       w_shift_p2;

  assign w_shift_p2 = w_rd & bus.clock_en & ~r_strobe & bus.io_port;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        r_shift_p2 <= '0;
    else if (r_strobe)   r_shift_p2 <= w_snap_nxt_p2;
    else if (w_shift_p2) r_shift_p2 <= {1'b1, r_shift_p2[7:1]};
  end

  assign w_unused_bits = &{1'b0, bus.io_wr_data[7:1]};
`else
  assign w_unused_bits = &{1'b0, bus.io_wr_data[7:1], w_snap_nxt_p2};
`endif

  always_comb begin
    bus.io_rd_data = JOY_OPEN_BUS;
    if (w_rd && !bus.io_port)
      bus.io_rd_data[0] = r_strobe ? snap_p1[BTN_A] : r_shift_p1[0];
`ifdef JOYPAD_P2_EN
    if (w_rd && bus.io_port)
      bus.io_rd_data[0] = r_strobe ? snap_p2[BTN_A] : r_shift_p2[0];
`endif
  end

endmodule : joypad_if
`default_nettype wire
